write_port: RTL and testbench
=============================

Name: write_port

Overview:
- Write side of the 32x32 register file; owns the register storage.
- Drives all 32 register values to the read ports as one flat bus.
- Merges two writeback sources into one storage write per cycle:
  - the pipeline's primary writeback, which always wins;
  - the multdiv unit's auxiliary completion, which uses a valid/ready handshake.
- A 1-entry pending buffer absorbs an auxiliary write that collides with a primary write.

Parameters:
- DATA_WIDTH, 32, register width in bits
- NUM_REGS, 32, number of architectural registers
- ADDR_WIDTH, 5, register index width (clog2 of NUM_REGS)

Ports:
- clock  in  1  rising-edge clock
- ctrl_reset_n  in  1  asynchronous active-low reset
- ctrl_writeEnable  in  1  primary write request, no handshake
- ctrl_writeReg  in  ADDR_WIDTH  primary destination index
- data_writeReg  in  DATA_WIDTH  primary write data
- aux_valid  in  1  auxiliary write offered
- aux_ready  out  1  auxiliary write can be accepted
- aux_writeReg  in  ADDR_WIDTH  auxiliary destination index
- aux_data  in  DATA_WIDTH  auxiliary write data
- aux_pending  out  1  pending buffer occupied
- reg_data_flat  out  NUM_REGS*DATA_WIDTH  register i on bits [DATA_WIDTH*i +: DATA_WIDTH]

Behaviour:
- Reset (ctrl_reset_n=0, asynchronous):
  - all registers 0, pending buffer cleared, state IDLE;
  - aux_pending=0, aux_ready=1, held while reset is asserted;
  - reset mid-operation discards the held entry without writing it.
- Register 0 is hardwired to 0. Writes to index 0 are dropped but still complete their handshake.
- Port busy = ctrl_writeEnable, independent of ctrl_writeReg (a primary write to r0 still occupies the port).
- aux accepted = aux_valid && aux_ready; aux_ready = (state==IDLE), decoded from state only, no combinational path from aux_valid.
- State IDLE (buffer empty):
  - port busy, aux accepted -> primary written; aux captured into buffer; next HELD.
  - port free, aux accepted -> aux written directly at this edge; stay IDLE.
  - no aux accepted -> primary written if enabled; stay IDLE.
- State HELD (buffer full, aux_ready=0, aux_pending=1):
  - port busy -> primary written; buffer retained; stay HELD.
  - port free -> buffer entry written; next IDLE (aux_ready=1 the following cycle).
- At most one storage write per edge. The write lands at the edge; reg_data_flat reflects it from the next cycle. No internal bypass; forwarding is the pipeline's job.
- Same-index ordering: a buffered aux write committed after a primary write to the same index overwrites it (last committed wins).
- Max aux latency from acceptance to commit is unbounded under a continuous primary stream. The multdiv unit must hold aux_valid/data stable until accepted.
- Unknown/X on aux_* while aux_valid=0 must not affect state.

Decomposition:
- Package regfile_pkg: DATA_WIDTH, NUM_REGS, ADDR_WIDTH constants; 1-bit state enum {IDLE, HELD}.
- Sub-module: reuse the team's existing 5-to-32 one-hot decoder. It decodes the selected write index into per-register enables, gated by the final write-enable and masked at bit 0.

Test Plan:
- Reset, then primary write r5=0xDEADBEEF -> reg5 reads 0xDEADBEEF one cycle later; all other registers 0; aux_ready=1.
- Primary write r0=0xFFFFFFFF -> reg0 stays 0. aux write r0=0x1 with port free -> accepted (ready=1), reg0 stays 0.
- Same cycle: primary r3=0x11, aux r4=0x22 -> r3=0x11 next cycle; aux_pending=1, aux_ready=0; with enable low one cycle later r4=0x22; aux_pending=0.
- HELD with continuous primary writes for 4 cycles -> buffer retained, aux_ready stays 0; first free cycle commits aux; aux_valid offered meanwhile is not accepted.
- Collision on same index: primary r7=0xA and aux r7=0xB same cycle, then free cycle -> r7=0xA then r7=0xB.
- Assert ctrl_reset_n=0 asynchronously mid-cycle while HELD -> immediately all registers 0, aux_pending=0, aux_ready=1; held entry never written after release.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and state encoding for the register-file write side.
package regfile_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned ADDR_WIDTH = 5;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } state_e;

endpackage

// File: rtl/write_port_decoder.sv
// Index to one-hot write-enable decoder; output bit 0 is forced low so r0 never loads.
module write_port_decoder #(
  parameter int unsigned NumOut    = 32,
  parameter int unsigned AddrWidth = 5
) (
  input  logic                 en_i,
  input  logic [AddrWidth-1:0] addr_i,
  output logic [NumOut-1:0]    onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o[addr_i] = 1'b1;
    end
    onehot_o[0] = 1'b0;
  end

endmodule

// File: rtl/write_port.sv
// Register storage plus a write port merging primary writeback with a buffered aux source.
module write_port
  import regfile_pkg::*;
#(
  parameter int unsigned DataWidth = DATA_WIDTH,
  parameter int unsigned NumRegs   = NUM_REGS,
  parameter int unsigned AddrWidth = ADDR_WIDTH
) (
  input  logic                         clock,
  input  logic                         ctrl_reset_n,
  input  logic                         ctrl_writeEnable,
  input  logic [AddrWidth-1:0]         ctrl_writeReg,
  input  logic [DataWidth-1:0]         data_writeReg,
  input  logic                         aux_valid,
  output logic                         aux_ready,
  input  logic [AddrWidth-1:0]         aux_writeReg,
  input  logic [DataWidth-1:0]         aux_data,
  output logic                         aux_pending,
  output logic [NumRegs*DataWidth-1:0] reg_data_flat
);

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] pend_addr_q, pend_addr_d;
  logic [DataWidth-1:0] pend_data_q, pend_data_d;
  logic [DataWidth-1:0] regs_q [NumRegs];

  logic                 wr_en;
  logic [AddrWidth-1:0] wr_addr;
  logic [DataWidth-1:0] wr_data;
  logic [NumRegs-1:0]   wr_onehot;
  logic                 aux_accept;

  // Ready depends only on state so aux_valid never loops back combinationally.
  assign aux_ready   = (state_q == IDLE);
  assign aux_pending = (state_q == HELD);
  assign aux_accept  = aux_valid && aux_ready;

  always_comb begin
    state_d     = state_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    wr_en       = 1'b0;
    wr_addr     = ctrl_writeReg;
    wr_data     = data_writeReg;
    unique case (state_q)
      IDLE: begin
        if (ctrl_writeEnable) begin
          wr_en = 1'b1;
          if (aux_accept) begin
            pend_addr_d = aux_writeReg;
            pend_data_d = aux_data;
            state_d     = HELD;
          end
        end else if (aux_accept) begin
          wr_en   = 1'b1;
          wr_addr = aux_writeReg;
          wr_data = aux_data;
        end
      end
      HELD: begin
        wr_en = 1'b1;
        if (!ctrl_writeEnable) begin
          wr_addr = pend_addr_q;
          wr_data = pend_data_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state_q     <= IDLE;
      pend_addr_q <= '0;
      pend_data_q <= '0;
    end else begin
      state_q     <= state_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
    end
  end

  write_port_decoder #(
    .NumOut    (NumRegs),
    .AddrWidth (AddrWidth)
  ) u_decoder (
    .en_i     (wr_en),
    .addr_i   (wr_addr),
    .onehot_o (wr_onehot)
  );

  for (genvar i = 0; i < NumRegs; i++) begin : g_regs
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
      if (!ctrl_reset_n) begin
        regs_q[i] <= '0;
      end else if (wr_onehot[i]) begin
        regs_q[i] <= wr_data;
      end
    end
    assign reg_data_flat[DataWidth*i +: DataWidth] = regs_q[i];
  end

endmodule

// File: tb/tb_write_port.sv
// Directed plus random checks of write_port against a queue-based behavioural model.
module tb_write_port;

  logic        clock = 1'b0;
  logic        ctrl_reset_n;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic        aux_valid;
  logic        aux_ready;
  logic [4:0]  aux_writeReg;
  logic [31:0] aux_data;
  logic        aux_pending;
  logic [1023:0] reg_data_flat;

  always #5 clock = ~clock;

  write_port dut (
    .clock            (clock),
    .ctrl_reset_n     (ctrl_reset_n),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .aux_valid        (aux_valid),
    .aux_ready        (aux_ready),
    .aux_writeReg     (aux_writeReg),
    .aux_data         (aux_data),
    .aux_pending      (aux_pending),
    .reg_data_flat    (reg_data_flat)
  );

  int          total = 0;
  int          fails = 0;
  logic [31:0] mem [32];
  logic [36:0] pendq [$];  // {addr, data} of aux writes accepted but not yet committed
  bit          last_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd(input int i);
    return reg_data_flat[32*i +: 32];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mem[i] = '0;
    pendq.delete();
  endtask

  function automatic void model_write(input logic [4:0] a, input logic [31:0] d);
    if (a != 0) mem[a] = d;
  endfunction

  task automatic check_state(input string where);
    for (int i = 0; i < 32; i++) chk($sformatf("%s r%0d", where, i), rd(i), mem[i]);
    chk({where, " aux_pending"}, {31'b0, aux_pending}, {31'b0, pendq.size() != 0});
    chk({where, " aux_ready"}, {31'b0, aux_ready}, {31'b0, pendq.size() == 0});
  endtask

  task automatic drive(input bit en, input logic [4:0] wa, input logic [31:0] wd,
                       input bit av, input logic [4:0] aa, input logic [31:0] ad);
    ctrl_writeEnable = en;
    ctrl_writeReg    = wa;
    data_writeReg    = wd;
    aux_valid        = av;
    aux_writeReg     = aa;
    aux_data         = ad;
  endtask

  // Apply the write-merging rules to the model, then clock the DUT and compare.
  task automatic cycle(input string where);
    bit ready;
    ready = (pendq.size() == 0);
    chk({where, " pre-edge aux_ready"}, {31'b0, aux_ready}, {31'b0, ready});
    last_acc = (aux_valid === 1'b1) && ready;
    if (ctrl_writeEnable) begin
      model_write(ctrl_writeReg, data_writeReg);
      if (last_acc) pendq.push_back({aux_writeReg, aux_data});
    end else if (pendq.size() != 0) begin
      logic [36:0] e;
      e = pendq.pop_front();
      model_write(e[36:32], e[31:0]);
    end else if (last_acc) begin
      model_write(aux_writeReg, aux_data);
    end
    @(posedge clock);
    #1;
    check_state(where);
  endtask

  initial begin
    ctrl_reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    #2;
    check_state("reset");
    @(posedge clock);
    #3;
    ctrl_reset_n = 1'b1;

    // Primary write lands at the edge
    drive(1, 5, 32'hDEADBEEF, 0, 0, 0);
    cycle("wr_r5");
    chk("r5 deadbeef", rd(5), 32'hDEADBEEF);

    // r0 is hardwired; aux to r0 still handshakes
    drive(1, 0, 32'hFFFFFFFF, 0, 0, 0);
    cycle("wr_r0_primary");
    drive(0, 0, 0, 1, 0, 32'h1);
    chk("aux_ready r0", {31'b0, aux_ready}, 32'd1);
    cycle("wr_r0_aux");
    chk("r0 zero", rd(0), 32'h0);

    // Collision: aux buffered, committed on the next free cycle
    drive(1, 3, 32'h11, 1, 4, 32'h22);
    cycle("collide");
    chk("r3 11", rd(3), 32'h11);
    chk("pending set", {31'b0, aux_pending}, 32'd1);
    chk("ready clear", {31'b0, aux_ready}, 32'd0);
    drive(0, 0, 0, 0, 0, 0);
    cycle("drain");
    chk("r4 22", rd(4), 32'h22);
    chk("pending clear", {31'b0, aux_pending}, 32'd0);

    // Held under a continuous primary stream
    drive(1, 10, 32'h100, 1, 11, 32'h33);
    cycle("hold_enter");
    for (int k = 0; k < 4; k++) begin
      drive(1, 5'(12 + k), 32'h200 + k, 1, 9, 32'h55);
      cycle($sformatf("hold_busy%0d", k));
      chk("ready low held", {31'b0, aux_ready}, 32'd0);
    end
    drive(0, 0, 0, 1, 9, 32'h55);
    cycle("hold_free");
    chk("r11 33", rd(11), 32'h33);
    chk("r9 not yet", rd(9), 32'h0);
    cycle("second_aux");
    chk("r9 55", rd(9), 32'h55);

    // Same index: last committed wins
    drive(1, 7, 32'hA, 1, 7, 32'hB);
    cycle("same_idx");
    chk("r7 A", rd(7), 32'hA);
    drive(0, 0, 0, 0, 0, 0);
    cycle("same_idx_drain");
    chk("r7 B", rd(7), 32'hB);

    // Asynchronous reset while held discards the entry
    drive(1, 2, 32'h77, 1, 8, 32'hCAFE);
    cycle("pre_reset");
    drive(1, 2, 32'h78, 0, 0, 0);
    #3;
    ctrl_reset_n = 1'b0;
    #1;
    model_reset();
    check_state("async_reset");
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clock);
    #3;
    ctrl_reset_n = 1'b1;
    cycle("post_reset0");
    cycle("post_reset1");
    chk("r8 discarded", rd(8), 32'h0);

    // Random traffic; aux held stable until accepted, X on aux fields when idle
    last_acc = 1'b0;
    for (int n = 0; n < 400; n++) begin
      ctrl_writeEnable = ($urandom_range(0, 99) < 55);
      ctrl_writeReg    = 5'($urandom);
      data_writeReg    = $urandom;
      if (!(aux_valid === 1'b1 && !last_acc)) begin
        aux_valid = ($urandom_range(0, 99) < 45);
        if (aux_valid) begin
          aux_writeReg = 5'($urandom);
          aux_data     = $urandom;
        end else begin
          aux_writeReg = 'x;
          aux_data     = 'x;
        end
      end
      cycle($sformatf("rand%0d", n));
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
